// File: rtl/bitwise_logic_pipe.sv
// Registered bitwise logic unit with accumulator and a 2-entry result buffer.
// Results carry zero/all-ones flags captured at compute time.
module bitwise_logic_pipe #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned ACC_INIT = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic             in_acc,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_ones
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             ones;
    } entry_t;

    localparam logic [WIDTH-1:0] ACC_RST = WIDTH'(ACC_INIT);

    entry_t           mem_q [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic [WIDTH-1:0] acc;

    logic [WIDTH-1:0] a_eff;
    logic [WIDTH-1:0] res;
    entry_t           new_entry;
    entry_t           head;
    logic             push;
    logic             pop;

    assign a_eff = in_acc ? acc : in_a;

    always_comb begin
        res = '0;
        unique case (in_op)
            3'd0: res = a_eff & in_b;
            3'd1: res = a_eff | in_b;
            3'd2: res = a_eff ^ in_b;
            3'd3: res = ~(a_eff | in_b);
            3'd4: res = ~(a_eff & in_b);
            3'd5: res = ~(a_eff ^ in_b);
            3'd6: res = a_eff & ~in_b;
            3'd7: res = in_b;
        endcase
    end

    assign new_entry.result = res;
    assign new_entry.zero   = (res == '0);
    assign new_entry.ones   = (res == '1);

    // in_ready depends only on registered state and reset, never on out_ready
    assign in_ready  = !reset && (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign head       = mem_q[rd_ptr];
    assign out_result = out_valid ? head.result : '0;
    assign out_zero   = out_valid && head.zero;
    assign out_ones   = out_valid && head.ones;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count    <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            acc      <= ACC_RST;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr] <= new_entry;
                wr_ptr        <= ~wr_ptr;
                acc           <= res;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push && !pop) begin
                count <= count + 2'd1;
            end else if (pop && !push) begin
                count <= count - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Randomised and directed checks of bitwise_logic_pipe against a queue model.
// Outputs are sampled 1 time unit after each rising edge.
module tb_bitwise_logic_pipe;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   in_op = 3'd0;
    logic         in_acc = 1'b0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_result;
    logic         out_zero;
    logic         out_ones;

    int n_checks = 0;
    int n_fail = 0;

    logic [W-1:0] mq [$];
    logic [W-1:0] macc = '0;

    bitwise_logic_pipe #(.WIDTH(W), .ACC_INIT(0)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_acc     (in_acc),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_ones   (out_ones)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input int op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        logic [W-1:0] ones;
        ones = '1;
        case (op)
            0: return a & b;
            1: return a | b;
            2: return a ^ b;
            3: return ones ^ (a | b);
            4: return ones ^ (a & b);
            5: return ones ^ (a ^ b);
            6: return a & (ones ^ b);
            default: return b;
        endcase
    endfunction

    task automatic check_outputs();
        logic [W-1:0] hd;
        logic [W-1:0] all1;
        all1 = '1;
        hd = (mq.size() != 0) ? mq[0] : '0;
        check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        check("out_result", 64'(out_result), 64'(hd));
        check("out_zero", 64'(out_zero), 64'((mq.size() != 0) && (hd == 0)));
        check("out_ones", 64'(out_ones), 64'((mq.size() != 0) && (hd == all1)));
    endtask

    // One clock: drive inputs, check in_ready, advance model, check outputs
    task automatic step(input logic v, input int op, input logic acc,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ordy);
        logic         exp_rdy;
        logic         fire;
        logic         popx;
        logic [W-1:0] r;
        in_valid  = v;
        in_op     = 3'(op);
        in_acc    = acc;
        in_a      = a;
        in_b      = b;
        out_ready = ordy;
        exp_rdy = (mq.size() < 2);
        #1;
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        fire = v && exp_rdy;
        popx = ordy && (mq.size() > 0);
        r = ref_op(op, acc ? macc : a, b);
        @(posedge clock);
        #1;
        if (popx) void'(mq.pop_front());
        if (fire) begin
            mq.push_back(r);
            macc = r;
        end
        check_outputs();
    endtask

    logic [W-1:0] t1_exp [8];

    initial begin
        t1_exp[0] = 32'hF000_000F; t1_exp[1] = 32'hFFF0_0FFF;
        t1_exp[2] = 32'h0FF0_0FF0; t1_exp[3] = 32'h000F_F000;
        t1_exp[4] = 32'h0FFF_FFF0; t1_exp[5] = 32'hF00F_F00F;
        t1_exp[6] = 32'h00F0_00F0; t1_exp[7] = 32'hFF00_0F0F;

        #1;
        check("reset_in_ready", 64'(in_ready), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_result", 64'(out_result), 64'd0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        check("post_reset_in_ready", 64'(in_ready), 64'd1);

        // each op, one cycle latency
        for (int i = 0; i < 8; i++) begin
            step(1, i, 0, 32'hF0F0_00FF, 32'hFF00_0F0F, 1);
            check("op_result", 64'(out_result), 64'(t1_exp[i]));
        end
        step(0, 0, 0, 0, 0, 1);

        // flags
        step(1, 0, 0, 32'h0, 32'hDEAD_BEEF, 1);
        check("and0_zero", 64'(out_zero), 64'd1);
        check("and0_ones", 64'(out_ones), 64'd0);
        step(1, 3, 0, 32'h0, 32'h0, 1);
        check("nor_result", 64'(out_result), 64'hFFFF_FFFF);
        check("nor_ones", 64'(out_ones), 64'd1);

        // accumulate chain, no bubbles
        step(1, 7, 0, 32'h1234_5678, 32'h0000_FFFF, 1);
        check("acc1", 64'(out_result), 64'h0000_FFFF);
        step(1, 1, 1, 32'h1234_5678, 32'hFF00_0000, 1);
        check("acc2", 64'(out_result), 64'hFF00_FFFF);
        step(1, 2, 1, 32'h1234_5678, 32'hFFFF_FFFF, 1);
        check("acc3", 64'(out_result), 64'h00FF_0000);
        step(0, 0, 0, 0, 0, 1);

        // backpressure: third push refused until space frees
        step(1, 7, 0, 0, 32'h1, 0);
        step(1, 7, 0, 0, 32'h2, 0);
        check("bp_full_ready", 64'(in_ready), 64'd0);
        step(1, 7, 0, 0, 32'h3, 0);
        check("bp_hold_head", 64'(out_result), 64'h1);
        step(1, 7, 0, 0, 32'h3, 1);
        check("bp_head2", 64'(out_result), 64'h2);
        step(1, 7, 0, 0, 32'h3, 1);
        check("bp_head3", 64'(out_result), 64'h3);
        step(0, 0, 0, 0, 0, 1);
        check("bp_empty", 64'(out_valid), 64'd0);

        // simultaneous push/pop at count 1
        step(1, 7, 0, 0, 32'h100, 0);
        for (int i = 1; i <= 10; i++) begin
            step(1, 7, 0, 0, 32'h100 + 32'(i), 1);
            check("pp_result", 64'(out_result), 64'(32'h100 + 32'(i)));
            check("pp_count1", 64'(mq.size()), 64'd1);
        end
        step(0, 0, 0, 0, 0, 1);

        // randomised traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom(),
                 ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom(),
                 1'($urandom_range(0, 2) != 0));
        end
        while (mq.size() != 0) step(0, 0, 0, 0, 0, 1);

        // reset with two entries buffered and acc=0x1234
        step(1, 7, 0, 0, 32'h1234, 0);
        step(1, 0, 0, 32'h1234, 32'hFFFF, 0);
        reset = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        mq.delete();
        macc = '0;
        @(posedge clock); #1;
        reset = 1'b0;
        step(1, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        check("rst_acc_init", 64'(out_result), 64'h0);
        check("rst_acc_zero", 64'(out_zero), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
